// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receiver:
//   - state_t       : receiver FSM states
//   - PAR_*         : encodings of the PARITY parameter
//   - *_BIT         : bit positions inside the 16-bit status/data word
//   - OUT_EMPTY     : value of the status/data word when it holds no frame
//   - expected_parity() : parity bit a correct frame carries
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int READY_BIT = 15;
    localparam int FERR_BIT  = 14;
    localparam int PERR_BIT  = 13;
    localparam int OVR_BIT   = 12;

    localparam logic [15:0] OUT_EMPTY = 16'h8000;

    // Data bits above DATA_BITS-1 are always zero, so XOR over the whole
    // 9-bit field equals XOR over the real data bits.
    function automatic logic expected_parity(input logic [8:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
// CPU-side bundle of the UART receiver slot.
//   clear : synchronous acknowledge, empties the status/data word
//   RX    : asynchronous serial line, idles high
//   out   : 16-bit status/data word
// master : the CPU/line side (drives clear and RX, reads out)
// slave  : the receiver
// ---------------------------------------------------------------------------
interface uart_rx_param_if;
    logic        clear;
    logic        RX;
    logic [15:0] out;

    modport master (output clear, output RX, input out);
    modport slave  (input clear, input RX, output out);
endinterface

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Brings the asynchronous RX line into the clk domain and produces the bit
// value the receiver FSM uses when its bit counter reaches zero.
// Build option: UART_RX_MAJORITY_EN
//   defined   : sample_bit = 2-of-3 majority of rxs over the last three
//               cycles (counter values 2, 1, 0 at the sampling point)
//   undefined : sample_bit = rxs
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   rx         : raw serial line
//   rxs        : synchronised line (2-flop synchroniser, flops reset to 1)
//   sample_bit : filtered bit value for the sampling point
// ---------------------------------------------------------------------------
module uart_rx_sampler (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rxs,
    output logic sample_bit
);

    logic sync1_q;
    logic sync2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // sees the pre-edge value of the others (sync2_q takes the old sync1_q).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] = rxs one cycle ago, hist_q[1] = rxs two cycles ago.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    assign sample_bit = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_bit = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2
// stop bits. Completed frames land in a registered 16-bit status/data word
// that software polls and acknowledges with clear.
// Build option: UART_RX_MAJORITY_EN (majority-of-3 bit sampling, see
// uart_rx_sampler).
// Parameters: CLKS_PER_BIT (>= 8), DATA_BITS (5..9), PARITY (0/1/2),
//             STOP_BITS (1/2).
// Ports:
//   clk   : clock, all state updates on its rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of uart_rx_param_if (clear, RX in; out)
// out word: [15] empty, [14] framing err, [13] parity err, [12] overrun,
//           [11:9] zero, [8:0] data (LSB first on the line).
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input logic            clk,
    input logic            reset,
    uart_rx_param_if.slave bus
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_idx_q;
    logic [8:0]       shreg_q;
    logic [8:0]       shreg_shifted;
    logic             ferr_q, perr_q;
    logic [15:0]      out_q;
    logic [15:0]      commit_word;

    logic rxs, sample_bit, tick;
    logic start_frame, shift_en, par_en, stop_en, commit;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus.RX),
        .rxs        (rxs),
        .sample_bit (sample_bit)
    );

    assign tick = (cnt_q == '0);

    // ---- state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---- next-state logic ----
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rxs) state_d = START;
            START: if (tick) state_d = sample_bit ? IDLE : DATA;
            DATA:  if (tick && bit_idx_q == LAST_DATA)
                       state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (tick) state_d = STOP;
            STOP:  if (tick && bit_idx_q == LAST_STOP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- control outputs ----
    always_comb begin
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        stop_en     = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE:             start_frame = !rxs;
            DATA:             shift_en    = tick;
            uart_pkg::PARITY: par_en      = tick;
            STOP: begin
                stop_en = tick;
                commit  = tick && (bit_idx_q == LAST_STOP);
            end
            default: ;
        endcase
    end

    // New bit enters at DATA_BITS-1 and walks down, so after DATA_BITS
    // shifts the first (LSB) bit sits at position 0.
    always_comb begin
        shreg_shifted                = shreg_q >> 1;
        shreg_shifted[DATA_BITS - 1] = sample_bit;
    end

    // ---- datapath: bit counter, bit index, shift register, error flags ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (start_frame)            cnt_q <= CNT_HALF;
            else if (state_q != IDLE)   cnt_q <= tick ? CNT_FULL : cnt_q - CNT_W'(1);

            // Index restarts on every state change so DATA and STOP each
            // count their own samples from zero.
            if (state_d != state_q)         bit_idx_q <= '0;
            else if (shift_en || stop_en)   bit_idx_q <= bit_idx_q + 4'd1;

            if (shift_en) shreg_q <= shreg_shifted;

            if (start_frame) begin
                ferr_q <= 1'b0;
                perr_q <= 1'b0;
            end else begin
                if (par_en)                 perr_q <= (sample_bit != expected_parity(shreg_q, PARITY));
                if (stop_en && !sample_bit) ferr_q <= 1'b1;
            end
        end
    end

    // The last stop sample is folded in directly since ferr_q only sees it
    // one cycle later.
    always_comb begin
        commit_word            = '0;
        commit_word[8:0]       = shreg_q;
        commit_word[FERR_BIT]  = ferr_q | ~sample_bit;
        commit_word[PERR_BIT]  = perr_q;
        commit_word[OVR_BIT]   = ~out_q[READY_BIT];
    end

    // ---- output register: commit has priority over clear ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          out_q <= OUT_EMPTY;
        else if (commit)    out_q <= commit_word;
        else if (bus.clear) out_q <= OUT_EMPTY;
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Three receivers at 16 clocks per bit: A = 8N1, B = 7E1, C = 6O2.
// Table-driven frames, hand sequences for timing corner cases, and random
// frames checked against a line-level decoding model.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CPB = 16;

    typedef logic bitq_t[$];

    typedef struct {
        int          sel;
        logic [8:0]  data;
        bit          flip_par;
        int          bad_stop;   // 1-based stop bit driven low, 0 = none
        bit          clear_first;
        logic [15:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rx_line;
    logic [2:0] clr;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;
    bit unread [3];

    always #5 clk = ~clk;

    uart_rx_param_if if_a ();
    uart_rx_param_if if_b ();
    uart_rx_param_if if_c ();

    assign if_a.RX = rx_line[0];
    assign if_b.RX = rx_line[1];
    assign if_c.RX = rx_line[2];
    assign if_a.clear = clr[0];
    assign if_b.clear = clr[1];
    assign if_c.clear = clr[2];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(6), .PARITY(2), .STOP_BITS(2))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    function automatic int db_of(input int sel);
        case (sel) 0: return 8; 1: return 7; default: return 6; endcase
    endfunction
    function automatic int par_of(input int sel);
        case (sel) 0: return 0; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int sb_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    function automatic logic [15:0] out_of(input int sel);
        case (sel) 0: return if_a.out; 1: return if_b.out; default: return if_c.out; endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Line levels of one frame: start, data LSB first, parity, stop bits.
    function automatic bitq_t build_frame(input int sel, input logic [8:0] data,
                                          input bit flip_par, input int bad_stop);
        bitq_t      q;
        logic [8:0] d = '0;
        logic       p;
        q.push_back(1'b0);
        for (int i = 0; i < db_of(sel); i++) begin
            d[i] = data[i];
            q.push_back(data[i]);
        end
        if (par_of(sel) != 0) begin
            p = (^d) ^ (par_of(sel) == 2);
            q.push_back(p ^ flip_par);
        end
        for (int s = 1; s <= sb_of(sel); s++) q.push_back(s == bad_stop ? 1'b0 : 1'b1);
        return q;
    endfunction

    // Reference: decode the line levels into the word software should see.
    function automatic logic [15:0] model_word(input int sel, input bitq_t bits, input bit was_unread);
        logic [8:0] d = '0;
        logic       perr = 1'b0;
        logic       ferr = 1'b0;
        int         pos;
        for (int i = 0; i < db_of(sel); i++) d[i] = bits[1 + i];
        pos = 1 + db_of(sel);
        if (par_of(sel) != 0) begin
            perr = (bits[pos] != ((^d) ^ (par_of(sel) == 2)));
            pos++;
        end
        for (int s = 0; s < sb_of(sel); s++) if (bits[pos + s] == 1'b0) ferr = 1'b1;
        return {1'b0, ferr, perr, was_unread, 3'b000, d};
    endfunction

    // Called just after a rising edge; each level lasts CPB cycles.
    task automatic drive_bits(input int sel, input bitq_t bits);
        foreach (bits[i]) begin
            rx_line[sel] = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_line[sel] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int sel);
        clr[sel] = 1'b1;
        @(posedge clk);
        #1;
        clr[sel] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        bitq_t       bits;
        logic [15:0] exp;
        int          sel;
        int          lat_exp;

        vecs[0] = '{0, 9'h03C, 1'b0, 1, 1'b1, 16'h403C};
        vecs[1] = '{0, 9'h001, 1'b0, 0, 1'b1, 16'h0001};
        vecs[2] = '{1, 9'h055, 1'b1, 0, 1'b1, 16'h2055};
        vecs[3] = '{1, 9'h07F, 1'b0, 0, 1'b0, 16'h107F};
        vecs[4] = '{0, 9'h011, 1'b0, 0, 1'b1, 16'h0011};
        vecs[5] = '{0, 9'h022, 1'b0, 0, 1'b0, 16'h1022};
        vecs[6] = '{2, 9'h02A, 1'b0, 0, 1'b1, 16'h002A};
        vecs[7] = '{2, 9'h015, 1'b0, 2, 1'b0, 16'h5015};
        vecs[8] = '{2, 9'h03F, 1'b1, 0, 1'b1, 16'h203F};
        vecs[9] = '{1, 9'h000, 1'b0, 1, 1'b1, 16'h4000};

        lat_exp = 2 + CPB / 2 + (8 + 0 + 1) * CPB + 1;

        reset   = 1'b1;
        rx_line = 3'b111;
        clr     = 3'b000;
        idle(3);
        check("reset_a", if_a.out, 16'h8000);
        check("reset_b", if_b.out, 16'h8000);
        check("reset_c", if_c.out, 16'h8000);
        reset = 1'b0;
        idle(5);

        // 8N1 0xA5: latency from the falling edge, then clear.
        bits = build_frame(0, 9'h0A5, 1'b0, 0);
        lat  = -1;
        fork
            drive_bits(0, bits);
            begin
                for (int n = 1; n <= 200; n++) begin
                    @(posedge clk);
                    #2;
                    if (lat < 0 && if_a.out[15] == 1'b0) lat = n;
                end
            end
        join
        n_cmp++;
        if (lat < lat_exp - 1 || lat > lat_exp + 1) begin
            n_fail++;
            $display("FAIL latency_a5: got %0d cycles, expected %0d +/-1", lat, lat_exp);
        end
        check("a5_word", if_a.out, 16'h00A5);
        do_clear(0);
        check("a5_clear", if_a.out, 16'h8000);

        // Table of frames.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].clear_first) do_clear(vecs[i].sel);
            bits = build_frame(vecs[i].sel, vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop);
            drive_bits(vecs[i].sel, bits);
            idle(24);
            check($sformatf("vec%0d", i), out_of(vecs[i].sel), vecs[i].exp);
        end

        // Clear held in the commit cycle of 0x7E: the commit must win.
        do_clear(0);
        bits = build_frame(0, 9'h07E, 1'b0, 0);
        fork
            drive_bits(0, bits);
            begin
                repeat (lat_exp - 1) @(posedge clk);
                #1 clr[0] = 1'b1;
                @(posedge clk);
                #1 clr[0] = 1'b0;
            end
        join
        idle(4);
        check("clear_vs_commit", if_a.out, 16'h007E);

        // 3-cycle low glitch on idle line: false start, word untouched.
        rx_line[0] = 1'b0;
        idle(3);
        rx_line[0] = 1'b1;
        idle(40);
        check("false_start", if_a.out, 16'h007E);

        // Reset in the middle of a data bit.
        rx_line[0] = 1'b0;
        idle(CPB);
        rx_line[0] = 1'b1;
        idle(CPB);
        rx_line[0] = 1'b0;
        idle(CPB / 2);
        reset = 1'b1;
        #1;
        check("reset_mid_frame", if_a.out, 16'h8000);
        rx_line[0] = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(5);
        bits = build_frame(0, 9'h05A, 1'b0, 0);
        drive_bits(0, bits);
        idle(24);
        check("after_reset_5a", if_a.out, 16'h005A);
        unread[0] = 1'b1;
        unread[1] = 1'b0;
        unread[2] = 1'b0;

        // Random frames against the decoding model.
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) begin
                do_clear(sel);
                check($sformatf("rnd%0d_clear", k), out_of(sel), 16'h8000);
                unread[sel] = 1'b0;
            end
            bits = build_frame(sel, 9'($urandom),
                               (par_of(sel) != 0) && ($urandom_range(0, 3) == 0),
                               ($urandom_range(0, 3) == 0) ? $urandom_range(1, sb_of(sel)) : 0);
            exp  = model_word(sel, bits, unread[sel]);
            drive_bits(sel, bits);
            idle(24 + $urandom_range(0, 8));
            check($sformatf("rnd%0d_sel%0d", k, sel), out_of(sel), exp);
            unread[sel] = 1'b1;
        end

        // 0x96 with a 1-cycle inverted glitch on the sampling cycle of every bit.
        do_clear(0);
        bits = build_frame(0, 9'h096, 1'b0, 0);
        foreach (bits[i]) begin
            rx_line[0] = bits[i];
            idle(CPB / 2);
            rx_line[0] = ~bits[i];
            idle(1);
            rx_line[0] = bits[i];
            idle(CPB / 2 - 1);
        end
        rx_line[0] = 1'b1;
        idle(200);
`ifdef UART_RX_MAJORITY_EN
        check("glitch_majority", if_a.out, 16'h0096);
`else
        n_cmp++;
        if (if_a.out === 16'h0096) begin
            n_fail++;
            $display("FAIL glitch_single_sample: got %h, expected corrupted (not 0096)", if_a.out);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
